// File: rtl/otter_pkg.sv
// Shared definitions for the Otter core PC/CSR path.
//   PC_SEL_*      : PC mux select encodings (MTVEC and MEPC extend the base set)
//   CSR_*         : machine-mode CSR addresses served by csr_trap_unit
//   csr_op_t      : CSR instruction operation encoding
//   trap_state_t  : trap sequencer states
//   csr_rmw()     : read-modify-write result for a CSR operation
package otter_pkg;

    localparam logic [2:0] PC_SEL_NEXT   = 3'd0;
    localparam logic [2:0] PC_SEL_JALR   = 3'd1;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd2;
    localparam logic [2:0] PC_SEL_JAL    = 3'd3;
    localparam logic [2:0] PC_SEL_MTVEC  = 3'd4;
    localparam logic [2:0] PC_SEL_MEPC   = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } trap_state_t;

    function automatic logic [31:0] csr_rmw(input csr_op_t op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
        case (op)
            CSR_WRITE: csr_rmw = wdata;
            CSR_SET:   csr_rmw = old_val | wdata;
            CSR_CLEAR: csr_rmw = old_val & ~wdata;
            default:   csr_rmw = old_val;
        endcase
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output, STAGES edges after d settles
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and external-interrupt trap sequencer.
//   clk, rst_n            : core clock, asynchronous active-low reset
//   intr                  : asynchronous level interrupt request
//   pc_we                 : instruction boundary strobe
//   pc_count, next_addr   : current PC and PC+4
//   mret, csr_we          : instruction qualifiers (valid with pc_we)
//   csr_op/addr/wdata     : CSR instruction operands
//   csr_rdata             : old value of addressed CSR (combinational)
//   mtvec, mepc           : vectors consumed by the PC mux
//   pc_ovr_valid/sel      : PC mux override for trap entry / mret
//   int_taken             : one-cycle pulse after trap entry
module csr_trap_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        intr,
    input  logic        pc_we,
    input  logic [31:0] pc_count,
    input  logic [31:0] next_addr,
    input  logic        mret,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        pc_ovr_valid,
    output logic [2:0]  pc_ovr_sel,
    output logic        int_taken
);

    trap_state_t state_q, state_d;
    logic        pending;
    logic        mie_q, mpie_q, meie_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q;
    logic        csr_commit, trap_go, mret_go;
    logic [31:0] csr_new;

    // The current PC is not needed: the interrupted instruction completes,
    // so the return address is always next_addr.
    logic unused_pc;
    assign unused_pc = ^pc_count;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (intr),
        .q     (pending)
    );

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[3] = mie_q;
                csr_rdata[7] = mpie_q;
            end
            CSR_MIE:    csr_rdata[11] = meie_q;
            CSR_MTVEC:  csr_rdata     = mtvec_q;
            CSR_MEPC:   csr_rdata     = mepc_q;
            CSR_MCAUSE: csr_rdata     = mcause_q;
            CSR_MIP:    csr_rdata[11] = pending;
            default:    csr_rdata     = 32'h0;
        endcase
    end

    assign csr_commit = pc_we && csr_we && (csr_op != 2'b00);
    assign csr_new    = csr_rmw(csr_op_t'(csr_op), csr_rdata, csr_wdata);

    // Entry is only possible from RUN, which also rules out back-to-back
    // traps; an mret on the same boundary always takes precedence.
    assign trap_go = (state_q == RUN) && pc_we && pending && mie_q && meie_q && !mret;
    assign mret_go = (state_q == RUN) && pc_we && mret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_ovr_valid = 1'b0;
        pc_ovr_sel   = 3'd0;
        case (state_q)
            RUN: begin
                if (trap_go) begin
                    state_d      = TRAP;
                    pc_ovr_valid = 1'b1;
                    pc_ovr_sel   = PC_SEL_MTVEC;
                end else if (mret_go) begin
                    pc_ovr_valid = 1'b1;
                    pc_ovr_sel   = PC_SEL_MEPC;
                end
            end
            TRAP:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // CSR instruction results are applied first; trap entry and mret
    // assignments follow so they win on the fields they touch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET;
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
        end else begin
            if (csr_commit) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_q  <= csr_new[3];
                        mpie_q <= csr_new[7];
                    end
                    CSR_MIE:    meie_q   <= csr_new[11];
                    CSR_MTVEC:  mtvec_q  <= {csr_new[31:2], 2'b00};
                    CSR_MEPC:   mepc_q   <= {csr_new[31:2], 2'b00};
                    CSR_MCAUSE: mcause_q <= csr_new;
                    default: ;
                endcase
            end
            if (trap_go) begin
                mepc_q   <= {next_addr[31:2], 2'b00};
                mcause_q <= MCAUSE_EXT_INT;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_go) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

    assign mtvec     = mtvec_q;
    assign mepc      = mepc_q;
    assign int_taken = (state_q == TRAP);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed testbench for csr_trap_unit: CSR read-modify-write, interrupt
// entry, mret return, mret/interrupt priority and asynchronous reset.
module tb_csr_trap_unit;

    localparam logic [31:0] MTV_RST = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        intr;
    logic        pc_we;
    logic [31:0] pc_count;
    logic [31:0] next_addr;
    logic        mret;
    logic        csr_we;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pc_ovr_valid;
    logic [2:0]  pc_ovr_sel;
    logic        int_taken;

    int tests = 0;
    int fails = 0;

    csr_trap_unit #(.MTVEC_RESET(MTV_RST), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .intr         (intr),
        .pc_we        (pc_we),
        .pc_count     (pc_count),
        .next_addr    (next_addr),
        .mret         (mret),
        .csr_we       (csr_we),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .pc_ovr_valid (pc_ovr_valid),
        .pc_ovr_sel   (pc_ovr_sel),
        .int_taken    (int_taken)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        pc_we     = 1'b1;
        csr_we    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        step();
        pc_we     = 1'b0;
        csr_we    = 1'b0;
        csr_op    = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; intr = 1'b0; pc_we = 1'b0; pc_count = 32'h0; next_addr = 32'h0;
        mret = 1'b0; csr_we = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
        step();
        step();

        // Reset state
        chk("rst_mtvec", mtvec, MTV_RST);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_ovr_valid", {31'h0, pc_ovr_valid}, 32'h0);
        chk("rst_int_taken", {31'h0, int_taken}, 32'h0);
        rst_n = 1'b1;
        step();
        rd("rd_mtvec_rst", 12'h305, MTV_RST);
        rd("rd_mstatus_rst", 12'h300, 32'h0);

        // CSR write/set/clear
        csr_do(2'b01, 12'h305, 32'h0000_0103);
        chk("mtvec_aligned", mtvec, 32'h0000_0100);
        csr_do(2'b10, 12'h300, 32'h0000_0008);
        csr_do(2'b10, 12'h304, 32'h0000_0800);
        rd("mstatus_mie", 12'h300, 32'h0000_0008);
        rd("mie_meie", 12'h304, 32'h0000_0800);
        csr_do(2'b01, 12'h342, 32'hFFFF_FFFF);
        csr_do(2'b11, 12'h342, 32'h0000_FFFF);
        rd("mcause_clear", 12'h342, 32'hFFFF_0000);
        csr_do(2'b01, 12'h341, 32'h0000_0057);
        rd("mepc_aligned", 12'h341, 32'h0000_0054);
        csr_do(2'b01, 12'h123, 32'hDEAD_BEEF);
        rd("unimpl_reads0", 12'h123, 32'h0);
        // read-only op with pc_we must not modify
        csr_do(2'b00, 12'h342, 32'h0);
        rd("mcause_readonly_op", 12'h342, 32'hFFFF_0000);

        // Interrupt entry
        pc_we = 1'b1; pc_count = 32'h40; next_addr = 32'h44; csr_addr = 12'h300;
        intr = 1'b1;
        #1;
        chk("no_ovr_before_sync", {31'h0, pc_ovr_valid}, 32'h0);
        step();
        chk("no_ovr_after_1edge", {31'h0, pc_ovr_valid}, 32'h0);
        step();
        chk("trap_ovr_valid", {31'h0, pc_ovr_valid}, 32'h1);
        chk("trap_ovr_sel", {29'h0, pc_ovr_sel}, 32'h4);
        chk("no_pulse_yet", {31'h0, int_taken}, 32'h0);
        step();
        chk("int_taken_pulse", {31'h0, int_taken}, 32'h1);
        chk("trap_mepc", mepc, 32'h44);
        chk("trap_ovr_blocked", {31'h0, pc_ovr_valid}, 32'h0);
        rd("trap_mcause", 12'h342, 32'h8000_000B);
        rd("trap_mstatus", 12'h300, 32'h0000_0080);
        step();
        chk("int_taken_once", {31'h0, int_taken}, 32'h0);
        chk("mie0_no_retrap", {31'h0, pc_ovr_valid}, 32'h0);

        // mret restores MIE; held interrupt traps at next boundary
        mret = 1'b1;
        #1;
        chk("mret_ovr_valid", {31'h0, pc_ovr_valid}, 32'h1);
        chk("mret_ovr_sel", {29'h0, pc_ovr_sel}, 32'h5);
        step();
        rd("mret_mstatus", 12'h300, 32'h0000_0088);
        mret = 1'b0;
        #1;
        chk("retrap_sel", {29'h0, pc_ovr_sel}, 32'h4);

        // mret with pending and MIE=1: mret wins
        mret = 1'b1; next_addr = 32'h88;
        #1;
        chk("prio_sel_mepc", {29'h0, pc_ovr_sel}, 32'h5);
        step();
        chk("prio_no_pulse", {31'h0, int_taken}, 32'h0);
        chk("prio_mepc_kept", mepc, 32'h44);
        rd("prio_mcause_kept", 12'h342, 32'h8000_000B);

        // Take trap, then reset while in TRAP
        mret = 1'b0;
        step();
        chk("trap2_pulse", {31'h0, int_taken}, 32'h1);
        chk("trap2_mepc", mepc, 32'h88);
        rd("trap2_mip", 12'h344, 32'h0000_0800);
        intr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_int_taken", {31'h0, int_taken}, 32'h0);
        chk("arst_mepc", mepc, 32'h0);
        chk("arst_mtvec", mtvec, MTV_RST);
        chk("arst_ovr_valid", {31'h0, pc_ovr_valid}, 32'h0);
        rd("arst_mip", 12'h344, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_no_pulse", {31'h0, int_taken}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
